// File: rtl/grf_sb_bypass_if.sv
// Register file bus: read ports, writeback, and scoreboard issue.
interface grf_sb_bypass_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) ();
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     iss_ovf;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, iss_ovf
    );
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, iss_ovf
    );
endinterface

// File: rtl/grf_sb_bypass.sv
// Register file with write-to-read bypass and per-register pending-write scoreboard.
// Optional simulation trace of writes and dropped issues: define GRF_TRACE_EN.
module grf_sb_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PEND_W = 2,
    parameter int NREG   = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0]              addr,
    input  logic [NREG-1:0][DATA_W-1:0]    regs,
    input  logic [NREG-1:0][PEND_W-1:0]    cnt,
    input  logic                           wr_live,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    output logic [DATA_W-1:0]              data,
    output logic                           busy
);
    logic hit;
    assign hit = wr_live && (wr_addr == addr) && (addr != '0);

    always_comb begin
        data = '0;
        if (addr == '0)  data = '0;
        else if (hit)    data = wr_data;
        else             data = regs[addr];
    end

    // A write retiring the last pending entry clears busy now; bypass carries the value.
    assign busy = (addr != '0) && (cnt[addr] != '0) &&
                  !(hit && cnt[addr] == PEND_W'(1));
endmodule

module grf_sb_bypass #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int PEND_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    grf_sb_bypass_if.slave  bus
);
    localparam int              NREG    = 2**ADDR_W;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [NREG-1:0][DATA_W-1:0] regs;
    logic [NREG-1:0][PEND_W-1:0] cnt;
    logic                        ovf_q;
    logic                        wr_hit, iss_hit, iss_drop, wr_live;
    logic [NREG-1:0]             iss_sel, ret_sel;

    assign wr_hit   = bus.wr_en  && (bus.wr_addr  != '0);
    assign iss_hit  = bus.iss_en && (bus.iss_addr != '0);
    assign wr_live  = bus.wr_en && !reset;
    assign iss_sel  = iss_hit ? (NREG'(1) << bus.iss_addr) : '0;
    assign ret_sel  = wr_hit  ? (NREG'(1) << bus.wr_addr)  : '0;
    assign iss_drop = iss_hit && (cnt[bus.iss_addr] == CNT_MAX) &&
                      !(wr_hit && bus.wr_addr == bus.iss_addr);
    assign bus.iss_ovf = ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs  <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= iss_drop;
            if (wr_hit) regs[bus.wr_addr] <= bus.wr_data;
            // Issue and retire on the same register cancel out.
            for (int r = 1; r < NREG; r++) begin
                if (iss_sel[r] && !ret_sel[r] && cnt[r] != CNT_MAX)
                    cnt[r] <= cnt[r] + PEND_W'(1);
                else if (ret_sel[r] && !iss_sel[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - PEND_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        grf_sb_rd_port #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PEND_W(PEND_W), .NREG(NREG)
        ) u_port (
            .addr    (bus.rd_addr[i*ADDR_W +: ADDR_W]),
            .regs    (regs),
            .cnt     (cnt),
            .wr_live (wr_live),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .data    (bus.rd_data[i*DATA_W +: DATA_W]),
            .busy    (bus.rd_busy[i])
        );
    end

`ifdef GRF_TRACE_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (wr_hit)   $display("%t: $%d <= %h", $time, bus.wr_addr, bus.wr_data);
            if (iss_drop) $display("%t: GRF issue overflow $%d", $time, bus.iss_addr);
        end
    end
`endif
endmodule
